load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit_pkg.sv | 19 +
 rtl/load_unit_align_extend.sv | 25 ++
 rtl/load_unit.sv | 85 ++++++++
 tb/tb_load_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// load_unit_pkg: load funct3 encodings, FSM states and the request legality check.
package load_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} state_t;

    // True for an illegal funct3 or a halfword/word access off its natural alignment.
    function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] a);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) ||
               (((f3 == F3_LH) || (f3 == F3_LHU)) && a[0]) ||
               ((f3 == F3_LW) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/load_unit_align_extend.sv
// load_align_extend: selects the addressed byte/halfword of a little-endian word and extends it.
module load_align_extend
    import load_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = addr[1] ? (addr[0] ? word[31:24] : word[23:16])
                    : (addr[0] ? word[15:8]  : word[7:0]);
        h = addr[1] ? word[31:16] : word[15:0];
        value = (funct3 == F3_LB)  ? {{24{b[7]}}, b}  :
                (funct3 == F3_LH)  ? {{16{h[15]}}, h} :
                (funct3 == F3_LW)  ? word             :
                (funct3 == F3_LBU) ? {24'd0, b}       :
                (funct3 == F3_LHU) ? {16'd0, h}       : 32'd0;
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: one-at-a-time RISC-V load engine with memory and result valid/ready handshakes.
module load_unit
    import load_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        res_err
);

    state_t      state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] aligned;

    assign req_ready = (state == S_IDLE);
    assign mem_addr  = {addr_q[31:2], 2'b00};

    load_align_extend u_align (
        .word   (mem_rsp_data),
        .addr   (addr_q[1:0]),
        .funct3 (funct3_q),
        .value  (aligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            funct3_q      <= '0;
            mem_req_valid <= 1'b0;
            res_valid     <= 1'b0;
            res_err       <= 1'b0;
            res_data      <= '0;
            res_rd        <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    addr_q   <= req_addr;
                    funct3_q <= req_funct3;
                    res_rd   <= req_rd;
                    if (load_bad(req_funct3, req_addr[1:0])) begin
                        state     <= S_ERR;
                        res_valid <= 1'b1;
                        res_err   <= 1'b1;
                        res_data  <= '0;
                    end else begin
                        state         <= S_REQ;
                        mem_req_valid <= 1'b1;
                    end
                end
                S_REQ: if (mem_req_ready) begin
                    state         <= S_WAIT;
                    mem_req_valid <= 1'b0;
                end
                S_WAIT: if (mem_rsp_valid) begin
                    state     <= S_RESP;
                    res_valid <= 1'b1;
                    res_err   <= 1'b0;
                    res_data  <= aligned;
                end
                S_RESP, S_ERR: if (res_ready) begin
                    state     <= S_IDLE;
                    res_valid <= 1'b0;
                    res_err   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed-vector self-checking bench for load_unit.
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_err;

    int checks = 0;
    int failures = 0;
    int res_count = 0;
    int base;

    always #5 clk = ~clk;

    load_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_funct3    (req_funct3),
        .req_rd        (req_rd),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_rd        (res_rd),
        .res_err       (res_err)
    );

    always @(posedge clk)
        if (rst_n && res_valid && res_ready) res_count <= res_count + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr = a;
        req_funct3 = f3;
        req_rd = rd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic finish_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("res_valid_cleared", {31'd0, res_valid}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] word,
                           input logic [31:0] exp_maddr, input logic [31:0] exp_data);
        accept(a, f3, rd);
        check({tag, "_mreq"}, {31'd0, mem_req_valid}, 32'd1);
        check({tag, "_maddr"}, mem_addr, exp_maddr);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check({tag, "_mreq_drop"}, {31'd0, mem_req_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = word;
        step();
        mem_rsp_valid = 1'b0;
        mem_rsp_data = 32'h0;
        check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_data"}, res_data, exp_data);
        check({tag, "_err"}, {31'd0, res_err}, 32'd0);
        check({tag, "_rd"}, {27'd0, res_rd}, {27'd0, rd});
        finish_result();
    endtask

    task automatic do_err(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [4:0] rd);
        accept(a, f3, rd);
        check({tag, "_no_mreq"}, {31'd0, mem_req_valid}, 32'd0);
        check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_err"}, {31'd0, res_err}, 32'd1);
        check({tag, "_data"}, res_data, 32'd0);
        check({tag, "_rd"}, {27'd0, res_rd}, {27'd0, rd});
        finish_result();
    endtask

    initial begin
        step();
        step();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_mreq", {31'd0, mem_req_valid}, 32'd0);
        check("rst_err", {31'd0, res_err}, 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_rd", {27'd0, res_rd}, 32'd0);
        rst_n = 1'b1;
        step();

        // Stray response in IDLE must not produce a result.
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h11223344;
        step();
        mem_rsp_valid = 1'b0;
        check("stray_rsp_idle", {31'd0, res_valid}, 32'd0);

        do_load("lh_102", 32'h0000_0102, 3'b001, 5'd3, 32'hAAAA5555, 32'h100, 32'hFFFFAAAA);
        do_load("lhu_100", 32'h0000_0100, 3'b101, 5'd4, 32'hAAAA8001, 32'h100, 32'h00008001);
        do_load("lbu_103", 32'h0000_0103, 3'b100, 5'd5, 32'hAAAA8001, 32'h100, 32'h000000AA);
        do_load("lb_101", 32'h0000_0101, 3'b000, 5'd6, 32'h12348056, 32'h100, 32'hFFFFFF80);
        do_load("lb_102", 32'h0000_0102, 3'b000, 5'd7, 32'h12348056, 32'h100, 32'h00000034);
        do_load("lh_100", 32'h0000_0100, 3'b001, 5'd8, 32'h12348056, 32'h100, 32'hFFFF8056);
        do_load("lw_104", 32'h0000_0104, 3'b010, 5'd9, 32'h89ABCDEF, 32'h104, 32'h89ABCDEF);
        do_load("lhu_102", 32'hFFFF_FFFE, 3'b101, 5'd31, 32'hF00F1234, 32'hFFFFFFFC, 32'h0000F00F);
        do_load("lbu_100", 32'h0000_0100, 3'b100, 5'd1, 32'h000000FE, 32'h100, 32'h000000FE);

        do_err("lw_103", 32'h0000_0103, 3'b010, 5'd10);
        do_err("lh_101", 32'h0000_0101, 3'b001, 5'd11);
        do_err("lhu_103", 32'h0000_0103, 3'b101, 5'd12);
        do_err("f3_110", 32'h0000_0100, 3'b110, 5'd13);
        do_err("f3_011", 32'h0000_0100, 3'b011, 5'd14);
        do_err("f3_111", 32'h0000_0100, 3'b111, 5'd15);

        // Backpressure on both sides, with a stray response while the request is pending.
        base = res_count;
        accept(32'h0000_0200, 3'b010, 5'd20);
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data = 32'hBAD0BAD0;
            check("bp_mreq_hold", {31'd0, mem_req_valid}, 32'd1);
            check("bp_maddr_hold", mem_addr, 32'h200);
            step();
        end
        mem_rsp_valid = 1'b0;
        check("bp_no_early_res", {31'd0, res_valid}, 32'd0);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        check("bp_wait_idle", {31'd0, res_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'hDEADBEEF;
        step();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_res_valid_hold", {31'd0, res_valid}, 32'd1);
            check("bp_data_hold", res_data, 32'hDEADBEEF);
            check("bp_rd_hold", {27'd0, res_rd}, 32'd20);
            if (i < 2) step();
        end
        finish_result();
        step();
        check("bp_one_result", res_count - base, 32'd1);
        check("bp_idle_again", {31'd0, req_ready}, 32'd1);

        // Reset during WAIT, then a late response.
        accept(32'h0000_0302, 3'b001, 5'd17);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h7FFF1234;
        step();
        mem_rsp_valid = 1'b0;
        check("rstw_res_valid", {31'd0, res_valid}, 32'd0);
        check("rstw_req_ready", {31'd0, req_ready}, 32'd1);
        check("rstw_mreq", {31'd0, mem_req_valid}, 32'd0);
        check("rstw_data", res_data, 32'd0);
        check("rstw_rd", {27'd0, res_rd}, 32'd0);
        step();
        check("rstw_res_valid_late", {31'd0, res_valid}, 32'd0);

        do_load("post_rst_lh", 32'h0000_0302, 3'b001, 5'd18, 32'h7FFF1234, 32'h300, 32'h00007FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
